// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 device-to-host receiver with byte FIFO, break counter; optional PS2_RX_TIMEOUT_EN frame timeout
module ps2_rx_fifo #(
    parameter int DEPTH_LOG2     = 3,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       ready,
    input  logic       nextdata_n,
    output logic       overflow,
    output logic [7:0] key_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [2:0]            ps2c_sync_q, ps2c_sync_d;
    logic [1:0]            ps2d_sync_q, ps2d_sync_d;
    logic [3:0]            bitcnt_q, bitcnt_d;
    logic [9:0]            shift_q, shift_d;
    logic [DEPTH_LOG2:0]   wptr_q, wptr_d;
    logic [DEPTH_LOG2:0]   rptr_q, rptr_d;
    logic [7:0]            mem_q [DEPTH];
    logic [7:0]            mem_d [DEPTH];
    logic                  overflow_q, overflow_d;
    logic                  brk_q, brk_d;
    logic [7:0]            key_count_q, key_count_d;

    logic                  fall;
    logic                  ps2d;
    logic                  frame_ok;
    logic [7:0]            rx_byte;
    logic                  empty;
    logic                  full;
    logic                  pop;
    logic                  push;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
`endif

    // s0 is bit 0, s2 is bit 2; a high-to-low step between s2 and s1 marks a PS/2 clock fall
    assign fall    = ps2c_sync_q[2] & ~ps2c_sync_q[1];
    assign ps2d    = ps2d_sync_q[1];
    assign rx_byte = shift_q[8:1];

    assign empty = (wptr_q == rptr_q);
    assign full  = ((wptr_q ^ rptr_q) == {1'b1, {DEPTH_LOG2{1'b0}}});
    assign pop   = ~nextdata_n & ~empty;
    // a pop on the same edge frees the slot, so a full FIFO can still accept
    assign push  = frame_ok & (~full | pop);

    assign ready     = ~empty;
    assign data      = empty ? 8'h00 : mem_q[rptr_q[DEPTH_LOG2-1:0]];
    assign overflow  = overflow_q;
    assign key_count = key_count_q;

    // synchronizers, bit counter, shift register and frame check
    always_comb begin
        ps2c_sync_d = {ps2c_sync_q[1:0], ps2_clk};
        ps2d_sync_d = {ps2d_sync_q[0], ps2_data};
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        frame_ok    = 1'b0;
        if (fall) begin
            if (bitcnt_q == 4'd10) begin
                // start in shift_q[0], data in [8:1], parity in [9]; stop is the live bit
                bitcnt_d = 4'd0;
                frame_ok = ~shift_q[0] & ps2d & (^shift_q[9:1]);
            end else begin
                bitcnt_d = bitcnt_q + 4'd1;
                shift_d  = {ps2d, shift_q[9:1]};
            end
        end
`ifdef PS2_RX_TIMEOUT_EN
        tcnt_d = tcnt_q;
        if (fall || bitcnt_q == 4'd0) begin
            tcnt_d = '0;
        end else if (tcnt_q == TLAST) begin
            // stalled mid-frame too long: abandon the partial frame
            tcnt_d   = '0;
            bitcnt_d = 4'd0;
            shift_d  = '0;
        end else begin
            tcnt_d = tcnt_q + 1'b1;
        end
`endif
    end

    // FIFO pointers, storage, sticky overflow and break-sequence counter
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        mem_d       = mem_q;
        overflow_d  = overflow_q;
        brk_d       = brk_q;
        key_count_d = key_count_q;
        if (push) begin
            mem_d[wptr_q[DEPTH_LOG2-1:0]] = rx_byte;
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (frame_ok && full && !pop) begin
            overflow_d = 1'b1;
        end
        // counting follows frame acceptance, regardless of whether the push fit
        if (frame_ok) begin
            if (rx_byte == 8'hF0) begin
                brk_d = 1'b1;
            end else if (brk_q) begin
                brk_d       = 1'b0;
                key_count_d = key_count_q + 8'd1;
            end
        end
    end

    // state registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ps2c_sync_q <= '0;
            ps2d_sync_q <= '0;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            mem_q       <= '{default: '0};
            overflow_q  <= 1'b0;
            brk_q       <= 1'b0;
            key_count_q <= '0;
        end else begin
            ps2c_sync_q <= ps2c_sync_d;
            ps2d_sync_q <= ps2d_sync_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            mem_q       <= mem_d;
            overflow_q  <= overflow_d;
            brk_q       <= brk_d;
            key_count_q <= key_count_d;
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    // mid-frame idle counter
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - self-checking bench for ps2_rx_fifo with a queue-based reference model
module tb_ps2_rx_fifo;

    localparam int HALF = 5;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic [7:0] key_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mq[$];
    logic       m_ovf;
    logic       m_brk;
    logic [7:0] m_kc;

    ps2_rx_fifo #(.DEPTH_LOG2(3), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .data(data), .ready(ready), .nextdata_n(nextdata_n),
        .overflow(overflow), .key_count(key_count)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par);
        logic par;
        par = ~(^b) ^ bad_par;
        return {1'b1, par, b, 1'b0};
    endfunction

    function automatic void model_clear();
        mq.delete();
        m_ovf = 1'b0;
        m_brk = 1'b0;
        m_kc  = 8'h00;
    endfunction

    function automatic void model_accept(input logic [7:0] b);
        if (b == 8'hF0) m_brk = 1'b1;
        else if (m_brk) begin
            m_brk = 1'b0;
            m_kc  = m_kc + 8'd1;
        end
        if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovf = 1'b1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        model_clear();
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_cycle();
        @(negedge clk);
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
    endtask

    // sends bits 0..nbits-1; optionally pulses a pop onto the push edge of the stop bit
    task automatic send_frame(input logic [10:0] bits, input int nbits, input bit pop_at_stop);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10 && pop_at_stop) begin
                @(negedge clk);
                @(negedge clk);
                nextdata_n = 1'b0;
                @(negedge clk);
                nextdata_n = 1'b1;
                repeat (HALF - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({ready, data, overflow, key_count} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset: ready=%0b data=%h ovf=%0b kc=%h, required all 0", ready, data, overflow, key_count);
        end
    endtask

    task automatic test_single();
        send_frame(make_frame(8'h1C, 1'b0), 10, 1'b0);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_tests++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: ready=%0b required 0 after 2 clk", ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (ready !== 1'b1 || data !== 8'h1C) begin
            n_fail++;
            $display("FAIL latency_3clk: ready=%0b data=%h required 1 1c", ready, data);
        end
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        pop_cycle();
        n_tests++;
        if (ready !== 1'b0 || data !== 8'h00) begin
            n_fail++;
            $display("FAIL single_pop: ready=%0b data=%h required 0 00", ready, data);
        end
    endtask

    task automatic test_break_sequence();
        logic [7:0] seq [3];
        seq[0] = 8'h1C; seq[1] = 8'hF0; seq[2] = 8'h1C;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_frame(make_frame(seq[i], 1'b0), 11, 1'b0);
            model_accept(seq[i]);
        end
        n_tests++;
        if (key_count !== m_kc || m_kc !== 8'h01) begin
            n_fail++;
            $display("FAIL break_count: key_count=%h required %h", key_count, m_kc);
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (ready !== 1'b1 || data !== mq[0]) begin
                n_fail++;
                $display("FAIL break_order[%0d]: ready=%0b data=%h required 1 %h", i, ready, data, mq[0]);
            end
            pop_cycle();
            void'(mq.pop_front());
        end
        n_tests++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL break_empty: ready=%0b required 0", ready);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       bad;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            b   = ($urandom_range(0, 3) == 0) ? 8'hF0 : 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            send_frame(make_frame(b, bad), 11, 1'b0);
            if (!bad) model_accept(b);
            if ($urandom_range(0, 2) == 0 && mq.size() > 0) begin
                n_tests++;
                if (ready !== 1'b1 || data !== mq[0]) begin
                    n_fail++;
                    $display("FAIL rand_head[%0d]: ready=%0b data=%h required 1 %h", i, ready, data, mq[0]);
                end
                pop_cycle();
                void'(mq.pop_front());
            end
        end
        n_tests++;
        if (key_count !== m_kc || overflow !== m_ovf) begin
            n_fail++;
            $display("FAIL rand_status: kc=%h ovf=%0b required %h %0b", key_count, overflow, m_kc, m_ovf);
        end
        while (mq.size() > 0) begin
            n_tests++;
            if (ready !== 1'b1 || data !== mq[0]) begin
                n_fail++;
                $display("FAIL rand_drain: ready=%0b data=%h required 1 %h", ready, data, mq[0]);
            end
            pop_cycle();
            void'(mq.pop_front());
        end
        n_tests++;
        if (ready !== 1'b0 || data !== 8'h00) begin
            n_fail++;
            $display("FAIL rand_empty: ready=%0b data=%h required 0 00", ready, data);
        end
    endtask

    task automatic test_parity_error();
        do_reset();
        send_frame(make_frame(8'h1C, 1'b1), 11, 1'b0);
        n_tests++;
        if (ready !== 1'b0 || key_count !== 8'h00) begin
            n_fail++;
            $display("FAIL parity_drop: ready=%0b kc=%h required 0 00", ready, key_count);
        end
        send_frame(make_frame(8'h32, 1'b0), 11, 1'b0);
        n_tests++;
        if (ready !== 1'b1 || data !== 8'h32) begin
            n_fail++;
            $display("FAIL parity_recover: ready=%0b data=%h required 1 32", ready, data);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            send_frame(make_frame(8'(i), 1'b0), 11, 1'b0);
            model_accept(8'(i));
        end
        n_tests++;
        if (overflow !== 1'b1 || m_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: overflow=%0b required 1", overflow);
        end
        for (int i = 1; i <= 8; i++) begin
            n_tests++;
            if (ready !== 1'b1 || data !== 8'(i)) begin
                n_fail++;
                $display("FAIL ovf_order[%0d]: ready=%0b data=%h required 1 %h", i, ready, data, 8'(i));
            end
            pop_cycle();
        end
        n_tests++;
        if (ready !== 1'b0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: ready=%0b ovf=%0b required 0 1", ready, overflow);
        end
        do_reset();
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: overflow=%0b required 0", overflow);
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 8'hEF));
            send_frame(make_frame(b, 1'b0), 11, 1'b0);
            mq.push_back(b);
        end
        b = 8'hA5;
        send_frame(make_frame(b, 1'b0), 11, 1'b1);
        void'(mq.pop_front());
        mq.push_back(b);
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fullpop_ovf: overflow=%0b required 0", overflow);
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (ready !== 1'b1 || data !== mq[0]) begin
                n_fail++;
                $display("FAIL fullpop_order[%0d]: ready=%0b data=%h required 1 %h", i, ready, data, mq[0]);
            end
            pop_cycle();
            void'(mq.pop_front());
        end
        n_tests++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fullpop_occupancy: ready=%0b required 0 after 8 pops", ready);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        send_frame(make_frame(8'($urandom), 1'b0), 6, 1'b0);
        do_reset();
        send_frame(make_frame(8'h45, 1'b0), 11, 1'b0);
        n_tests++;
        if (ready !== 1'b1 || data !== 8'h45) begin
            n_fail++;
            $display("FAIL midreset_rx: ready=%0b data=%h required 1 45", ready, data);
        end
        pop_cycle();
        n_tests++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_single: ready=%0b required 0", ready);
        end
    endtask

`ifdef PS2_RX_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        send_frame(make_frame(8'($urandom), 1'b0), 5, 1'b0);
        repeat (150) @(negedge clk);
        send_frame(make_frame(8'h16, 1'b0), 11, 1'b0);
        n_tests++;
        if (ready !== 1'b1 || data !== 8'h16) begin
            n_fail++;
            $display("FAIL timeout_rx: ready=%0b data=%h required 1 16", ready, data);
        end
    endtask
`endif

    initial begin
        model_clear();
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        repeat (4) @(negedge clk);
        test_reset();
        test_single();
        test_break_sequence();
        test_random();
        test_parity_error();
        test_overflow();
        test_full_pop();
        test_reset_mid_frame();
`ifdef PS2_RX_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
